// File: rtl/regfile_scoreboard_pkg.sv
// Shared sizing helpers for the register file and its write-pending scoreboard.
// RF_SLICE picks port idx (width w) out of a packed multi-port bus.
package rf_pkg;

    localparam int CNT_W_DEFAULT = 2;

    function automatic int clog2(input int n);
        int w;
        w = 0;
        for (int k = 0; k < 31; k++) begin
            if ((1 << w) < n) begin
                w = w + 1;
            end
        end
        return (w == 0) ? 1 : w;
    endfunction

    function automatic int cnt_max(input int w);
        return (1 << w) - 1;
    endfunction

endpackage

`ifndef RF_SLICE
`define RF_SLICE(bus, idx, w) bus[(idx)*(w) +: (w)]
`endif

// File: rtl/rf_scoreboard.sv
// Per-register outstanding-write counters: claim acceptance, RAW busy flags
// and the unclaimed-write error pulse.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int NUM_RD   = 2,
    localparam int ADDR_W  = clog2(NUM_REGS)
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [NUM_RD*ADDR_W-1:0] rdAddr_i,
    output logic [NUM_RD-1:0]        rdBusy_o,
    input  logic                     claimEn_i,
    input  logic [ADDR_W-1:0]        claimAddr_i,
    output logic                     claimReady_o,
    input  logic                     wrEn_i,
    input  logic [ADDR_W-1:0]        wrAddr_i,
    input  logic                     flush_i,
    output logic                     errUnclaimed_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

    logic [CNT_W-1:0] cnt_q [NUM_REGS];
    logic [CNT_W-1:0] cnt_d [NUM_REGS];
    logic             err_q;
    logic             err_d;
    logic             wrLive;
    logic             claimZero;
    logic             claimTake;

    assign wrLive    = wrEn_i && !(ZERO_REG != 0 && wrAddr_i == '0);
    assign claimZero = (ZERO_REG != 0) && (claimAddr_i == '0);

    // A full counter can still take a claim when its own write retires this cycle.
    assign claimReady_o = !(cnt_q[claimAddr_i] == CNT_MAX &&
                            !(wrEn_i && wrAddr_i == claimAddr_i));
    assign claimTake    = claimEn_i && claimReady_o && !claimZero;

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            cnt_d[r] = cnt_q[r];
            if (flush_i) begin
                cnt_d[r] = '0;
            end else if (claimTake && claimAddr_i == ADDR_W'(r) &&
                         !(wrLive && wrAddr_i == ADDR_W'(r))) begin
                if (cnt_q[r] != CNT_MAX) begin
                    cnt_d[r] = cnt_q[r] + 1'b1;
                end
            end else if (wrLive && wrAddr_i == ADDR_W'(r) &&
                         !(claimTake && claimAddr_i == ADDR_W'(r))) begin
                if (cnt_q[r] != '0) begin
                    cnt_d[r] = cnt_q[r] - 1'b1;
                end
            end
        end
    end

    assign err_d = wrLive && (cnt_q[wrAddr_i] == '0) &&
                   !(claimTake && claimAddr_i == wrAddr_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    assign errUnclaimed_o = err_q;

    // With bypass, the last pending write retiring this cycle clears busy early.
    for (genvar i = 0; i < NUM_RD; i++) begin : g_busy
        logic [ADDR_W-1:0] a;
        assign a = `RF_SLICE(rdAddr_i, i, ADDR_W);
        assign rdBusy_o[i] = (cnt_q[a] != '0) &&
                             !(ZERO_REG != 0 && a == '0) &&
                             !(BYPASS != 0 && wrEn_i && wrAddr_i == a &&
                               cnt_q[a] == CNT_W'(1));
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// Multi-port register file with write-back bypass and a write-pending
// scoreboard for RAW hazard detection in the issue stage.
module regfile_scoreboard
    import rf_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    parameter int CNT_W    = CNT_W_DEFAULT,
    localparam int ADDR_W  = clog2(NUM_REGS)
) (
    input  logic                     SYS_clk,
    input  logic                     SYS_reset,
    input  logic [NUM_RD*ADDR_W-1:0] RF_rd_addr,
    output logic [NUM_RD*DATA_W-1:0] RF_rd_data,
    output logic [NUM_RD-1:0]        RF_rd_busy,
    input  logic                     RF_claim_en,
    input  logic [ADDR_W-1:0]        RF_claim_addr,
    output logic                     RF_claim_ready,
    input  logic                     RF_wr_en,
    input  logic [ADDR_W-1:0]        RF_wr_addr,
    input  logic [DATA_W-1:0]        RF_wr_data,
    input  logic                     RF_flush,
    output logic                     RF_err_unclaimed,
    input  logic [ADDR_W-1:0]        RF_dbg_addr,
    output logic [DATA_W-1:0]        RF_dbg_data
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];
    logic              wrCommit;

    assign wrCommit = RF_wr_en && !(ZERO_REG != 0 && RF_wr_addr == '0);

    always_ff @(posedge SYS_clk or posedge SYS_reset) begin
        if (SYS_reset) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                mem_q[r] <= '0;
            end
        end else if (wrCommit) begin
            mem_q[RF_wr_addr] <= RF_wr_data;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] rdWord;
        assign a = `RF_SLICE(RF_rd_addr, i, ADDR_W);
        always_comb begin
            rdWord = mem_q[a];
            if (ZERO_REG != 0 && a == '0) begin
                rdWord = '0;
            end else if (BYPASS != 0 && RF_wr_en && RF_wr_addr == a) begin
                rdWord = RF_wr_data;
            end
        end
        assign `RF_SLICE(RF_rd_data, i, DATA_W) = rdWord;
    end

    // Entry 0 is never written when ZERO_REG is set, so no masking is needed here.
    assign RF_dbg_data = mem_q[RF_dbg_addr];

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .CNT_W    (CNT_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk_i          (SYS_clk),
        .rst_i          (SYS_reset),
        .rdAddr_i       (RF_rd_addr),
        .rdBusy_o       (RF_rd_busy),
        .claimEn_i      (RF_claim_en),
        .claimAddr_i    (RF_claim_addr),
        .claimReady_o   (RF_claim_ready),
        .wrEn_i         (RF_wr_en),
        .wrAddr_i       (RF_wr_addr),
        .flush_i        (RF_flush),
        .errUnclaimed_o (RF_err_unclaimed)
    );

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: default build driven from a vector table with a
// write scoreboard on the debug port, plus no-bypass and 3-port/16-reg builds.
module tb_regfile_scoreboard;

    typedef struct {
        logic        claimEn;
        logic [4:0]  claimAddr;
        logic        wrEn;
        logic [4:0]  wrAddr;
        logic [31:0] wrData;
        logic        flush;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] expRd0;
        logic [31:0] expRd1;
        logic [1:0]  expBusy;
        logic        expReady;
        logic        expErr;
    } vec_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } sb_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int testsRun = 0;
    int testsFailed = 0;

    // Default build (BYPASS=1, ZERO_REG=1)
    logic [9:0]  aRdAddr;
    logic [63:0] aRdData;
    logic [1:0]  aRdBusy;
    logic        aClaimEn, aClaimReady, aWrEn, aFlush, aErr;
    logic [4:0]  aClaimAddr, aWrAddr, aDbgAddr;
    logic [31:0] aWrData, aDbgData;

    // No-bypass build
    logic [9:0]  bRdAddr;
    logic [63:0] bRdData;
    logic [1:0]  bRdBusy;
    logic        bClaimEn, bClaimReady, bWrEn, bFlush, bErr;
    logic [4:0]  bClaimAddr, bWrAddr, bDbgAddr;
    logic [31:0] bWrData, bDbgData;

    // Three read ports, 16 x 16-bit
    logic [11:0] cRdAddr;
    logic [47:0] cRdData;
    logic [2:0]  cRdBusy;
    logic        cClaimEn, cClaimReady, cWrEn, cFlush, cErr;
    logic [3:0]  cClaimAddr, cWrAddr, cDbgAddr;
    logic [15:0] cWrData, cDbgData;

    regfile_scoreboard uA (
        .SYS_clk(clk), .SYS_reset(rst),
        .RF_rd_addr(aRdAddr), .RF_rd_data(aRdData), .RF_rd_busy(aRdBusy),
        .RF_claim_en(aClaimEn), .RF_claim_addr(aClaimAddr), .RF_claim_ready(aClaimReady),
        .RF_wr_en(aWrEn), .RF_wr_addr(aWrAddr), .RF_wr_data(aWrData),
        .RF_flush(aFlush), .RF_err_unclaimed(aErr),
        .RF_dbg_addr(aDbgAddr), .RF_dbg_data(aDbgData)
    );

    regfile_scoreboard #(.BYPASS(0)) uB (
        .SYS_clk(clk), .SYS_reset(rst),
        .RF_rd_addr(bRdAddr), .RF_rd_data(bRdData), .RF_rd_busy(bRdBusy),
        .RF_claim_en(bClaimEn), .RF_claim_addr(bClaimAddr), .RF_claim_ready(bClaimReady),
        .RF_wr_en(bWrEn), .RF_wr_addr(bWrAddr), .RF_wr_data(bWrData),
        .RF_flush(bFlush), .RF_err_unclaimed(bErr),
        .RF_dbg_addr(bDbgAddr), .RF_dbg_data(bDbgData)
    );

    regfile_scoreboard #(.NUM_RD(3), .NUM_REGS(16), .DATA_W(16)) uC (
        .SYS_clk(clk), .SYS_reset(rst),
        .RF_rd_addr(cRdAddr), .RF_rd_data(cRdData), .RF_rd_busy(cRdBusy),
        .RF_claim_en(cClaimEn), .RF_claim_addr(cClaimAddr), .RF_claim_ready(cClaimReady),
        .RF_wr_en(cWrEn), .RF_wr_addr(cWrAddr), .RF_wr_data(cWrData),
        .RF_flush(cFlush), .RF_err_unclaimed(cErr),
        .RF_dbg_addr(cDbgAddr), .RF_dbg_data(cDbgData)
    );

    vec_t vecs[18];
    sb_t  sbQ[$];

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    function automatic vec_t mkVec(input logic ce, input logic [4:0] ca,
                                   input logic we, input logic [4:0] wa,
                                   input logic [31:0] wd, input logic fl,
                                   input logic [4:0] r0, input logic [31:0] e0,
                                   input logic [1:0] eb, input logic er,
                                   input logic ee);
        vec_t v;
        v.claimEn = ce;  v.claimAddr = ca;
        v.wrEn = we;     v.wrAddr = wa;   v.wrData = wd;
        v.flush = fl;
        v.rd0 = r0;      v.rd1 = 5'd5;
        v.expRd0 = e0;   v.expRd1 = 32'hDEADBEEF;
        v.expBusy = eb;  v.expReady = er; v.expErr = ee;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        aClaimEn   = v.claimEn;
        aClaimAddr = v.claimAddr;
        aWrEn      = v.wrEn;
        aWrAddr    = v.wrAddr;
        aWrData    = v.wrData;
        aFlush     = v.flush;
        aRdAddr    = {v.rd1, v.rd0};
    endtask

    task automatic idleAll();
        aClaimEn = 0; aClaimAddr = 0; aWrEn = 0; aWrAddr = 0; aWrData = 0;
        aFlush = 0; aRdAddr = 0; aDbgAddr = 0;
        bClaimEn = 0; bClaimAddr = 0; bWrEn = 0; bWrAddr = 0; bWrData = 0;
        bFlush = 0; bRdAddr = 0; bDbgAddr = 0;
        cClaimEn = 0; cClaimAddr = 0; cWrEn = 0; cWrAddr = 0; cWrData = 0;
        cFlush = 0; cRdAddr = 0; cDbgAddr = 0;
    endtask

    initial begin
        sb_t e;
        logic [4:0]  cAddr [3];
        logic [15:0] cData [3];

        rst = 1'b1;
        idleAll();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state on every register, both ports
        for (int r = 0; r < 32; r++) begin
            aRdAddr    = {5'(31 - r), 5'(r)};
            aClaimAddr = 5'(r);
            #1;
            checkOutput($sformatf("rst_rd0_r%0d", r), {32'h0, aRdData[31:0]}, 64'h0);
            checkOutput($sformatf("rst_rd1_r%0d", r), {32'h0, aRdData[63:32]}, 64'h0);
            checkOutput($sformatf("rst_busy_r%0d", r), {62'h0, aRdBusy}, 64'h0);
            checkOutput($sformatf("rst_ready_r%0d", r), {63'h0, aClaimReady}, 64'h1);
        end
        checkOutput("rst_err", {63'h0, aErr}, 64'h0);

        // Claim+write r9 (lands), claim r9 again, then reset during a write
        @(posedge clk); #1;
        aClaimEn = 1; aClaimAddr = 9; aWrEn = 1; aWrAddr = 9; aWrData = 32'h99;
        @(posedge clk); #1;
        aWrEn = 0;
        aDbgAddr = 9; aRdAddr = {5'd0, 5'd9};
        #1 checkOutput("pre_rst_r9", {32'h0, aDbgData}, 64'h99);
        checkOutput("pre_rst_err", {63'h0, aErr}, 64'h0);
        @(posedge clk); #1;
        aClaimEn = 0;
        #1 checkOutput("pre_rst_busy", {62'h0, aRdBusy}, 64'h1);
        aWrEn = 1; aWrData = 32'h1234;
        #2 rst = 1'b1;
        @(posedge clk); #1;
        aWrEn = 0;
        #1 rst = 1'b0;
        #1;
        checkOutput("midrst_dbg_r9", {32'h0, aDbgData}, 64'h0);
        checkOutput("midrst_rd_r9", {32'h0, aRdData[31:0]}, 64'h0);
        checkOutput("midrst_busy", {62'h0, aRdBusy}, 64'h0);
        checkOutput("midrst_err", {63'h0, aErr}, 64'h0);

        // claimEn, claimAddr, wrEn, wrAddr, wrData, flush, rd0, expRd0, expBusy, expReady, expErr
        vecs[0]  = mkVec(0, 0, 1, 5, 32'hDEADBEEF, 0, 5, 32'hDEADBEEF, 2'b00, 1, 0);
        vecs[1]  = mkVec(0, 0, 0, 0, 32'h0,        0, 5, 32'hDEADBEEF, 2'b00, 1, 1);
        vecs[2]  = mkVec(1, 7, 0, 0, 32'h0,        0, 7, 32'h0,        2'b00, 1, 0);
        vecs[3]  = mkVec(1, 7, 0, 0, 32'h0,        0, 7, 32'h0,        2'b01, 1, 0);
        vecs[4]  = mkVec(1, 7, 0, 0, 32'h0,        0, 7, 32'h0,        2'b01, 1, 0);
        vecs[5]  = mkVec(1, 7, 1, 7, 32'h70,       0, 7, 32'h70,       2'b01, 1, 0);
        vecs[6]  = mkVec(1, 7, 0, 0, 32'h0,        0, 7, 32'h70,       2'b01, 0, 0);
        vecs[7]  = mkVec(0, 7, 1, 7, 32'h71,       0, 7, 32'h71,       2'b01, 1, 0);
        vecs[8]  = mkVec(0, 7, 1, 7, 32'h72,       0, 7, 32'h72,       2'b01, 1, 0);
        vecs[9]  = mkVec(0, 7, 1, 7, 32'h73,       0, 7, 32'h73,       2'b00, 1, 0);
        vecs[10] = mkVec(0, 7, 0, 0, 32'h0,        0, 7, 32'h73,       2'b00, 1, 0);
        vecs[11] = mkVec(1, 3, 0, 0, 32'h0,        0, 3, 32'h0,        2'b00, 1, 0);
        vecs[12] = mkVec(0, 3, 1, 3, 32'h55,       1, 3, 32'h55,       2'b00, 1, 0);
        vecs[13] = mkVec(0, 3, 1, 3, 32'h56,       0, 3, 32'h56,       2'b00, 1, 0);
        vecs[14] = mkVec(0, 3, 0, 0, 32'h0,        0, 3, 32'h56,       2'b00, 1, 1);
        vecs[15] = mkVec(0, 3, 0, 0, 32'h0,        0, 3, 32'h56,       2'b00, 1, 0);
        vecs[16] = mkVec(1, 0, 1, 0, 32'hFFFFFFFF, 0, 0, 32'h0,        2'b00, 1, 0);
        vecs[17] = mkVec(0, 0, 0, 0, 32'h0,        0, 0, 32'h0,        2'b00, 1, 0);

        @(posedge clk); #1;
        for (int i = 0; i < 18; i++) begin
            applyStimulus(vecs[i]);
            if (vecs[i].wrEn) begin
                e.addr = vecs[i].wrAddr;
                e.data = (vecs[i].wrAddr == 5'd0) ? 32'h0 : vecs[i].wrData;
                sbQ.push_back(e);
            end
            #2;
            checkOutput($sformatf("v%0d_rd0", i), {32'h0, aRdData[31:0]}, {32'h0, vecs[i].expRd0});
            checkOutput($sformatf("v%0d_rd1", i), {32'h0, aRdData[63:32]}, {32'h0, vecs[i].expRd1});
            checkOutput($sformatf("v%0d_busy", i), {62'h0, aRdBusy}, {62'h0, vecs[i].expBusy});
            checkOutput($sformatf("v%0d_ready", i), {63'h0, aClaimReady}, {63'h0, vecs[i].expReady});
            checkOutput($sformatf("v%0d_err", i), {63'h0, aErr}, {63'h0, vecs[i].expErr});
            @(posedge clk); #1;
            while (sbQ.size() > 0) begin
                e = sbQ.pop_front();
                aDbgAddr = e.addr;
                #1 checkOutput($sformatf("v%0d_dbg_r%0d", i, e.addr), {32'h0, aDbgData}, {32'h0, e.data});
            end
        end
        idleAll();

        // No bypass: old value during the write cycle, new value after
        @(posedge clk); #1;
        bWrEn = 1; bWrAddr = 5; bWrData = 32'hDEADBEEF; bRdAddr = {5'd0, 5'd5};
        #2 checkOutput("nobyp_same_cycle", {32'h0, bRdData[31:0]}, 64'h0);
        @(posedge clk); #1;
        bWrEn = 0;
        #1 checkOutput("nobyp_next_cycle", {32'h0, bRdData[31:0]}, 64'hDEADBEEF);
        bClaimEn = 1; bClaimAddr = 7;
        @(posedge clk); #1;
        bClaimEn = 0; bWrEn = 1; bWrAddr = 7; bWrData = 32'h77; bRdAddr = {5'd0, 5'd7};
        #1;
        checkOutput("nobyp_busy_final_wr", {62'h0, bRdBusy}, 64'h1);
        checkOutput("nobyp_rd_final_wr", {32'h0, bRdData[31:0]}, 64'h0);
        @(posedge clk); #1;
        bWrEn = 0;
        #1;
        checkOutput("nobyp_busy_after", {62'h0, bRdBusy}, 64'h0);
        checkOutput("nobyp_rd_after", {32'h0, bRdData[31:0]}, 64'h77);

        // Three ports over 16 x 16-bit registers
        cAddr[0] = 5'd1;  cData[0] = 16'h1111;
        cAddr[1] = 5'd2;  cData[1] = 16'h2222;
        cAddr[2] = 5'd14; cData[2] = 16'hEEEE;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            cWrEn = 1; cWrAddr = cAddr[k][3:0]; cWrData = cData[k];
        end
        @(posedge clk); #1;
        cWrEn = 0;
        cRdAddr = {cAddr[2][3:0], cAddr[1][3:0], cAddr[0][3:0]};
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("p3_rd%0d", k), {48'h0, cRdData[k*16 +: 16]}, {48'h0, cData[k]});
            cDbgAddr = cAddr[k][3:0];
            #1 checkOutput($sformatf("p3_dbg_r%0d", cAddr[k]), {48'h0, cDbgData}, {48'h0, cData[k]});
        end
        checkOutput("p3_busy", {61'h0, cRdBusy}, 64'h0);
        cRdAddr = {4'd15, 4'd0, 4'd2};
        #1;
        checkOutput("p3_rd_mixed", {16'h0, cRdData}, {16'h0, 16'h0000, 16'h0000, 16'h2222});

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
